// File: rtl/rgb_packer_pkg.sv
// rtl/rgb_packer_pkg.sv - shared types and constants for the RGB-to-SRAM packer
//
// Purpose : holds the packer FSM state enum and the words-per-pixel-pair constant.
// Ports   : none (package).

package rgb_packer_pkg;

    // Two 24-bit pixels (48 bits) fit exactly in three 16-bit SRAM words.
    localparam int WORDS_PER_PAIR = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GET_P0  = 3'd1,
        S_GET_P1  = 3'd2,
        S_WRITE_0 = 3'd3,
        S_WRITE_1 = 3'd4,
        S_WRITE_2 = 3'd5,
        S_DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/rgb_sram_packer.sv
// rtl/rgb_sram_packer.sv - packs RGB888 pixel pairs into three 16-bit SRAM writes
//
// Purpose : after an accepted Start, collects pixel pairs from a valid/ready
//           stream and writes each pair as W0={R0,G0}, W1={B0,R1}, W2={G1,B1}
//           to consecutive SRAM words starting at the latched base address.
//           A frame ends after 3*FRAME_PIXELS/2 words with a Frame_done pulse.
// Ports   : Clock_50, Reset (sync, active-high)
//           Start, Base_address[17:0]         frame request and first word address
//           Pixel_valid/Pixel_ready, Pixel_R/G/B[7:0]   pixel stream
//           SRAM_ready, SRAM_address[17:0], SRAM_write_data[15:0], SRAM_we_n
//           Busy, Frame_done
//           Abort (only when RGB_SRAM_PACKER_ABORT_EN is defined)
// Options : RGB_SRAM_PACKER_ABORT_EN adds the Abort input.

module rgb_sram_packer
    import rgb_packer_pkg::*;
#(
    parameter int          FRAME_PIXELS = 76800,
    parameter logic [17:0] RESET_BASE   = 18'h00000
) (
    input  logic        Clock_50,
    input  logic        Reset,
    input  logic        Start,
    input  logic [17:0] Base_address,
    input  logic        Pixel_valid,
    output logic        Pixel_ready,
    input  logic [7:0]  Pixel_R,
    input  logic [7:0]  Pixel_G,
    input  logic [7:0]  Pixel_B,
    input  logic        SRAM_ready,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        Busy,
    output logic        Frame_done
`ifdef RGB_SRAM_PACKER_ABORT_EN
    ,
    input  logic        Abort
`endif
);

    localparam logic [31:0] TOTAL_WORDS = 32'(WORDS_PER_PAIR * FRAME_PIXELS / 2);

    if (FRAME_PIXELS <= 0 || (FRAME_PIXELS % 2) != 0) begin : g_bad_frame_pixels
        $error("FRAME_PIXELS must be even and non-zero");
    end

    logic abort_w;
`ifdef RGB_SRAM_PACKER_ABORT_EN
    assign abort_w = Abort;
`else
    assign abort_w = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [17:0] base_q, base_d;
    logic [31:0] word_idx_q, word_idx_d;
    logic [7:0]  r0_q, r0_d, g0_q, g0_d, b0_q, b0_d;
    logic [7:0]  r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
    logic        we_n_q, we_n_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        accept;

    // Abort gates ready so a pixel is never consumed in the cycle we abandon the frame.
    assign Pixel_ready = (state_q == S_GET_P0 || state_q == S_GET_P1) && SRAM_ready && !abort_w;
    assign accept      = Pixel_valid && Pixel_ready;

    // State register
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. SRAM_ready is only consulted at Start and in the pixel
    // states, so a triple that has begun always completes.
    always_comb begin
        state_d = state_q;
        if (abort_w && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (Start && SRAM_ready) state_d = S_GET_P0;
                S_GET_P0:  if (accept) state_d = S_GET_P1;
                S_GET_P1:  if (accept) state_d = S_WRITE_0;
                S_WRITE_0: state_d = S_WRITE_1;
                S_WRITE_1: state_d = S_WRITE_2;
                // word_idx_q already counts the W2 word here
                S_WRITE_2: state_d = (word_idx_q == TOTAL_WORDS) ? S_DONE : S_GET_P0;
                S_DONE:    state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Output / datapath logic. Registered outputs are computed from the state
    // being entered, so they are valid during the cycle the FSM sits in it.
    always_comb begin
        base_d       = base_q;
        word_idx_d   = word_idx_q;
        r0_d         = r0_q;
        g0_d         = g0_q;
        b0_d         = b0_q;
        r1_d         = r1_q;
        g1_d         = g1_q;
        b1_d         = b1_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_n_d       = 1'b1;
        busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
        frame_done_d = (state_d == S_DONE);

        if (state_q == S_IDLE && state_d == S_GET_P0) begin
            base_d     = Base_address;
            word_idx_d = '0;
        end
        if (state_q == S_GET_P0 && accept) begin
            r0_d = Pixel_R;
            g0_d = Pixel_G;
            b0_d = Pixel_B;
        end
        if (state_q == S_GET_P1 && accept) begin
            r1_d = Pixel_R;
            g1_d = Pixel_G;
            b1_d = Pixel_B;
        end

        if (state_d == S_WRITE_0 || state_d == S_WRITE_1 || state_d == S_WRITE_2) begin
            we_n_d     = 1'b0;
            // 18-bit truncation gives the modulo wrap past 18'h3FFFF
            addr_d     = 18'(32'(base_q) + word_idx_q);
            word_idx_d = word_idx_q + 32'd1;
            case (state_d)
                S_WRITE_0: wdata_d = {r0_q, g0_q};
                S_WRITE_1: wdata_d = {b0_q, r1_q};
                default:   wdata_d = {g1_q, b1_q};
            endcase
        end
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            base_q       <= RESET_BASE;
            word_idx_q   <= '0;
            r0_q         <= '0;
            g0_q         <= '0;
            b0_q         <= '0;
            r1_q         <= '0;
            g1_q         <= '0;
            b1_q         <= '0;
            we_n_q       <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            base_q       <= base_d;
            word_idx_q   <= word_idx_d;
            r0_q         <= r0_d;
            g0_q         <= g0_d;
            b0_q         <= b0_d;
            r1_q         <= r1_d;
            g1_q         <= g1_d;
            b1_q         <= b1_d;
            we_n_q       <= we_n_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign SRAM_we_n       = we_n_q;
    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign Busy            = busy_q;
    assign Frame_done      = frame_done_q;

endmodule
